ab_link_arbiter: RTL and testbench

AB_LINK_ARBITER -- requirements
Module: ab_link_arbiter

---
 rtl/ab_link_pkg.sv | 17 +
 rtl/ab_link_arbiter_if.sv | 35 +++
 rtl/ab_link_stage.sv | 36 +++
 rtl/config.vh | 5 +
 rtl/ab_link_arbiter.sv | 133 +++++++++++++
 tb/tb_ab_link_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/ab_link_pkg.sv
// Shared types and constants for the two-source link arbiter.
`include "config.vh"
package ab_link_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT0 = 2'd1,
    ST_GRANT1 = 2'd2
  } state_t;

  localparam int BURST_MAX_DEFAULT = 4;
  localparam int BEAT_CNT_W        = 4;
  localparam int DATA_W            = `DATA_TO_B_BITWIDTH;
  // Sideband bits carried beside the payload in the output register: {src, last}.
  localparam int SIDEBAND_W        = 2;

endpackage

// File: rtl/ab_link_arbiter_if.sv
// Bundle of both source streams and the merged output stream.
`include "config.vh"
interface ab_link_arbiter_if #(
  parameter int DATA_BITWIDTH = `DATA_TO_B_BITWIDTH
);
  logic                     s0_valid;
  logic                     s0_last;
  logic [DATA_BITWIDTH-1:0] s0_data;
  logic                     s0_ready;
  logic                     s1_valid;
  logic                     s1_last;
  logic [DATA_BITWIDTH-1:0] s1_data;
  logic                     s1_ready;
  logic                     m_valid;
  logic                     m_last;
  logic                     m_src;
  logic [DATA_BITWIDTH-1:0] m_data;
  logic                     m_ready;

  modport slave (
    input  s0_valid, s0_last, s0_data,
    input  s1_valid, s1_last, s1_data,
    input  m_ready,
    output s0_ready, s1_ready,
    output m_valid, m_last, m_src, m_data
  );

  modport master (
    output s0_valid, s0_last, s0_data,
    output s1_valid, s1_last, s1_data,
    output m_ready,
    input  s0_ready, s1_ready,
    input  m_valid, m_last, m_src, m_data
  );
endinterface

// File: rtl/ab_link_stage.sv
// One-entry valid/ready register; refills in the same cycle it drains.
module ab_link_stage #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data
);
  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  logic             w_load;

  assign o_ready = !r_valid || i_ready;
  assign w_load  = i_valid && o_ready;
  assign o_valid = r_valid;
  assign o_data  = r_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else begin
      if (o_ready) begin
        r_valid <= i_valid;
      end
      if (w_load) begin
        r_data <= i_data;
      end
    end
  end
endmodule

// File: rtl/config.vh
// Build-wide data width macros shared by the arbiter package, interface and top.
`ifndef AB_LINK_CONFIG_VH
`define AB_LINK_CONFIG_VH
`define DATA_TO_B_BITWIDTH 8
`endif

// File: rtl/ab_link_arbiter.sv
// Round-robin packet arbiter merging two sources into one stream, with a
// per-grant burst limit and a registered output stage.
`include "config.vh"
module ab_link_arbiter
  import ab_link_pkg::*;
#(
  parameter int DATA_BITWIDTH = `DATA_TO_B_BITWIDTH,
  parameter int BURST_MAX     = BURST_MAX_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  ab_link_arbiter_if.slave bus
);
  localparam int STAGE_W = DATA_BITWIDTH + SIDEBAND_W;

  state_t                   r_state;
  state_t                   w_next_state;
  logic                     r_rr_ptr;
  logic [BEAT_CNT_W-1:0]    r_beat_cnt;

  logic                     w_stage_ready;
  logic                     w_stage_valid;
  logic [STAGE_W-1:0]       w_stage_in;
  logic [STAGE_W-1:0]       w_stage_out;

  logic                     w_sel_valid;
  logic                     w_sel_last;
  logic                     w_sel_src;
  logic [DATA_BITWIDTH-1:0] w_sel_data;
  logic                     w_acc;
  logic                     w_burst_full;
  logic                     w_grant_end;

  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_last  = 1'b0;
    w_sel_src   = 1'b0;
    w_sel_data  = '0;
    case (r_state)
      ST_GRANT0: begin
        w_sel_valid = bus.s0_valid;
        w_sel_last  = bus.s0_last;
        w_sel_data  = bus.s0_data;
      end
      ST_GRANT1: begin
        w_sel_valid = bus.s1_valid;
        w_sel_last  = bus.s1_last;
        w_sel_data  = bus.s1_data;
        w_sel_src   = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.s0_ready = (r_state == ST_GRANT0) && w_stage_ready;
  assign bus.s1_ready = (r_state == ST_GRANT1) && w_stage_ready;

  assign w_acc        = w_sel_valid && w_stage_ready;
  assign w_burst_full = (r_beat_cnt + 1'b1) == BEAT_CNT_W'(BURST_MAX);
  // A burst-limit cut ends the grant but leaves m_last as the source drove it.
  assign w_grant_end  = w_acc && (w_sel_last || w_burst_full);

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (bus.s0_valid && bus.s1_valid) begin
          w_next_state = r_rr_ptr ? ST_GRANT1 : ST_GRANT0;
        end else if (bus.s0_valid) begin
          w_next_state = ST_GRANT0;
        end else if (bus.s1_valid) begin
          w_next_state = ST_GRANT1;
        end
      end
      ST_GRANT0: begin
        if (w_grant_end) begin
          w_next_state = bus.s1_valid ? ST_GRANT1 : ST_IDLE;
        end
      end
      ST_GRANT1: begin
        if (w_grant_end) begin
          w_next_state = bus.s0_valid ? ST_GRANT0 : ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Counter is zero on every grant entry: IDLE keeps it cleared and a
  // grant end clears it before a direct switch into the other grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr   <= 1'b0;
      r_beat_cnt <= '0;
    end else begin
      if (w_grant_end) begin
        r_rr_ptr   <= ~w_sel_src;
        r_beat_cnt <= '0;
      end else if (r_state == ST_IDLE) begin
        r_beat_cnt <= '0;
      end else if (w_acc) begin
        r_beat_cnt <= r_beat_cnt + 1'b1;
      end
    end
  end

  assign w_stage_in = {w_sel_src, w_sel_last, w_sel_data};

  ab_link_stage #(
    .WIDTH (STAGE_W)
  ) u_stage (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (w_sel_valid),
    .o_ready (w_stage_ready),
    .i_data  (w_stage_in),
    .o_valid (w_stage_valid),
    .i_ready (bus.m_ready),
    .o_data  (w_stage_out)
  );

  assign bus.m_valid = w_stage_valid;
  assign {bus.m_src, bus.m_last, bus.m_data} = w_stage_out;

endmodule

// File: tb/tb_ab_link_arbiter.sv
// Directed bench for ab_link_arbiter: reset, alternation, burst cuts, stalls, mid-burst reset.
module tb_ab_link_arbiter;
  import ab_link_pkg::*;

  localparam int BW = DATA_W + 1;
  localparam int OW = DATA_W + 2;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  logic [BW-1:0] q0[$];
  logic [BW-1:0] q1[$];
  logic [OW-1:0] out_q[$];
  int            out_cyc[$];
  bit            acc0, acc1;

  ab_link_arbiter_if bus_if ();

  ab_link_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  function automatic logic [OW-1:0] beat(input bit src, input bit last, input int d);
    return {src, last, DATA_W'(d)};
  endfunction

  // Output monitor and accept sampling, away from the rising edge.
  initial begin
    forever begin
      @(negedge clk);
      acc0 = rst_n && bus_if.s0_valid && bus_if.s0_ready;
      acc1 = rst_n && bus_if.s1_valid && bus_if.s1_ready;
      if (rst_n && bus_if.m_valid && bus_if.m_ready) begin
        out_q.push_back({bus_if.m_src, bus_if.m_last, bus_if.m_data});
        out_cyc.push_back(cyc);
      end
    end
  end

  // Source drivers: present the head of each queue, pop once accepted.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (acc0 && q0.size() > 0) void'(q0.pop_front());
      if (acc1 && q1.size() > 0) void'(q1.pop_front());
      acc0 = 1'b0;
      acc1 = 1'b0;
      bus_if.s0_valid = (q0.size() > 0);
      {bus_if.s0_last, bus_if.s0_data} = (q0.size() > 0) ? q0[0] : '0;
      bus_if.s1_valid = (q1.size() > 0);
      {bus_if.s1_last, bus_if.s1_data} = (q1.size() > 0) ? q1[0] : '0;
    end
  end

  task automatic wait_beats(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (out_q.size() >= n) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic clear_out();
    @(negedge clk);
    out_q.delete();
    out_cyc.delete();
  endtask

  task automatic test_reset();
    bit ok;
    logic [OW-1:0] exp[$];
    rst_n = 1'b0;
    bus_if.m_ready = 1'b1;
    bus_if.s0_valid = 1'b0; bus_if.s0_last = 1'b0; bus_if.s0_data = '0;
    bus_if.s1_valid = 1'b0; bus_if.s1_last = 1'b0; bus_if.s1_data = '0;
    q0.push_back({1'b1, DATA_W'('hA0)});
    q1.push_back({1'b1, DATA_W'('hB0)});
    exp.push_back(beat(1'b0, 1'b1, 'hA0));
    exp.push_back(beat(1'b1, 1'b1, 'hB0));
    repeat (3) @(negedge clk);
    checks++; if (bus_if.s0_valid !== 1'b1 || bus_if.s1_valid !== 1'b1) begin errors++; $display("FAIL rst_src_valid got %b%b need 11", bus_if.s0_valid, bus_if.s1_valid); end
    checks++; if (bus_if.m_valid !== 1'b0) begin errors++; $display("FAIL rst_m_valid got %b need 0", bus_if.m_valid); end
    checks++; if (bus_if.m_data !== '0) begin errors++; $display("FAIL rst_m_data got %h need 0", bus_if.m_data); end
    checks++; if (bus_if.m_last !== 1'b0) begin errors++; $display("FAIL rst_m_last got %b need 0", bus_if.m_last); end
    checks++; if (bus_if.m_src !== 1'b0) begin errors++; $display("FAIL rst_m_src got %b need 0", bus_if.m_src); end
    checks++; if (bus_if.s0_ready !== 1'b0) begin errors++; $display("FAIL rst_s0_ready got %b need 0", bus_if.s0_ready); end
    checks++; if (bus_if.s1_ready !== 1'b0) begin errors++; $display("FAIL rst_s1_ready got %b need 0", bus_if.s1_ready); end
    @(posedge clk); #1 rst_n = 1'b1;
    wait_beats(2, 50, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rst_timeout got %0d beats need 2", out_q.size()); end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (out_q.size() <= i || out_q[i] !== exp[i]) begin
        errors++;
        $display("FAIL rst_first_beat[%0d] got %h need %h", i, (out_q.size() > i) ? out_q[i] : '0, exp[i]);
      end
    end
    $display("test_reset: first beat src checked after release");
  endtask

  task automatic test_alternate();
    bit ok;
    logic [OW-1:0] exp[$];
    clear_out();
    for (int p = 0; p < 4; p++) begin
      for (int b = 0; b < 3; b++) begin
        bit s;
        int d;
        s = p[0];
        d = (s ? 'h20 : 'h10) + (p / 2) * 3 + b;
        if (s) q1.push_back({b == 2, DATA_W'(d)});
        else   q0.push_back({b == 2, DATA_W'(d)});
        exp.push_back(beat(s, b == 2, d));
      end
    end
    wait_beats(12, 200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL alt_timeout got %0d beats need 12", out_q.size()); end
    for (int i = 0; i < 12; i++) begin
      checks++;
      if (out_q.size() <= i || out_q[i] !== exp[i]) begin
        errors++;
        $display("FAIL alt_beat[%0d] got %h need %h", i, (out_q.size() > i) ? out_q[i] : '0, exp[i]);
      end
      if (i > 0 && out_q.size() > i) begin
        checks++;
        if (out_cyc[i] !== out_cyc[i-1] + 1) begin
          errors++;
          $display("FAIL alt_gap[%0d] got %0d need 1", i, out_cyc[i] - out_cyc[i-1]);
        end
      end
    end
    $display("test_alternate: %0d beats observed", out_q.size());
  endtask

  task automatic test_burst_cut();
    bit ok;
    logic [OW-1:0] exp[$];
    clear_out();
    for (int i = 0; i < 10; i++) begin
      q0.push_back({i == 9, DATA_W'('h30 + i)});
      exp.push_back(beat(1'b0, i == 9, 'h30 + i));
    end
    wait_beats(10, 200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL burst_timeout got %0d beats need 10", out_q.size()); end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (out_q.size() <= i || out_q[i] !== exp[i]) begin
        errors++;
        $display("FAIL burst_beat[%0d] got %h need %h", i, (out_q.size() > i) ? out_q[i] : '0, exp[i]);
      end
      if (i > 0 && out_q.size() > i) begin
        int gap;
        gap = (i == 4 || i == 8) ? 2 : 1;
        checks++;
        if (out_cyc[i] - out_cyc[i-1] !== gap) begin
          errors++;
          $display("FAIL burst_gap[%0d] got %0d need %0d", i, out_cyc[i] - out_cyc[i-1], gap);
        end
      end
    end
    $display("test_burst_cut: %0d beats observed", out_q.size());
  endtask

  task automatic test_burst_share();
    bit ok;
    logic [OW-1:0] exp[$];
    int order_s[5] = '{0, 1, 0, 1, 0};
    int order_n[5] = '{4, 3, 4, 3, 2};
    int i0 = 0;
    int i1 = 0;
    clear_out();
    for (int i = 0; i < 10; i++) q0.push_back({i == 9, DATA_W'('h40 + i)});
    @(negedge clk);
    for (int i = 0; i < 6; i++) q1.push_back({i == 2 || i == 5, DATA_W'('h50 + i)});
    for (int g = 0; g < 5; g++) begin
      for (int k = 0; k < order_n[g]; k++) begin
        if (order_s[g] == 0) begin
          exp.push_back(beat(1'b0, i0 == 9, 'h40 + i0));
          i0++;
        end else begin
          exp.push_back(beat(1'b1, i1 == 2 || i1 == 5, 'h50 + i1));
          i1++;
        end
      end
    end
    wait_beats(16, 300, ok);
    checks++; if (!ok) begin errors++; $display("FAIL share_timeout got %0d beats need 16", out_q.size()); end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (out_q.size() <= i || out_q[i] !== exp[i]) begin
        errors++;
        $display("FAIL share_beat[%0d] got %h need %h", i, (out_q.size() > i) ? out_q[i] : '0, exp[i]);
      end
      if (i > 0 && out_q.size() > i) begin
        checks++;
        if (out_cyc[i] !== out_cyc[i-1] + 1) begin
          errors++;
          $display("FAIL share_gap[%0d] got %0d need 1", i, out_cyc[i] - out_cyc[i-1]);
        end
      end
    end
    $display("test_burst_share: %0d beats observed", out_q.size());
  endtask

  task automatic test_stall();
    logic [BW-1:0] exp0[$];
    logic [BW-1:0] exp1[$];
    logic [OW-1:0] prev;
    bit prev_stall = 1'b0;
    int loops = 0;
    clear_out();
    for (int i = 0; i < 50; i++) begin
      logic [BW-1:0] b0, b1;
      b0 = {($urandom_range(0, 3) == 0) || (i == 49), DATA_W'($urandom)};
      b1 = {($urandom_range(0, 3) == 0) || (i == 49), DATA_W'($urandom)};
      q0.push_back(b0); exp0.push_back(b0);
      q1.push_back(b1); exp1.push_back(b1);
    end
    while (out_q.size() < 100 && loops < 3000) begin
      loops++;
      @(posedge clk);
      #1 bus_if.m_ready = ~bus_if.m_ready;
      @(negedge clk);
      if (prev_stall) begin
        checks++;
        if (bus_if.m_valid !== 1'b1 || {bus_if.m_src, bus_if.m_last, bus_if.m_data} !== prev) begin
          errors++;
          $display("FAIL stall_hold got v=%b %h need v=1 %h", bus_if.m_valid,
                   {bus_if.m_src, bus_if.m_last, bus_if.m_data}, prev);
        end
      end
      prev_stall = bus_if.m_valid && !bus_if.m_ready;
      prev = {bus_if.m_src, bus_if.m_last, bus_if.m_data};
    end
    @(posedge clk); #1 bus_if.m_ready = 1'b1;
    checks++; if (out_q.size() != 100) begin errors++; $display("FAIL stall_count got %0d need 100", out_q.size()); end
    for (int i = 0; i < out_q.size(); i++) begin
      logic [BW-1:0] want;
      bit s;
      s = out_q[i][OW-1];
      checks++;
      if ((s ? exp1.size() : exp0.size()) == 0) begin
        errors++;
        $display("FAIL stall_extra[%0d] got %h need none", i, out_q[i]);
      end else begin
        want = s ? exp1.pop_front() : exp0.pop_front();
        if (out_q[i][BW-1:0] !== want) begin
          errors++;
          $display("FAIL stall_beat[%0d] got %h need %h", i, out_q[i][BW-1:0], want);
        end
      end
    end
    checks++; if (exp0.size() + exp1.size() != 0) begin errors++; $display("FAIL stall_lost got %0d left need 0", exp0.size() + exp1.size()); end
    $display("test_stall: %0d beats scoreboarded", out_q.size());
  endtask

  task automatic test_reset_mid();
    bit ok;
    int n0;
    clear_out();
    for (int i = 0; i < 8; i++) q0.push_back({i == 7, DATA_W'('h60 + i)});
    wait_beats(2, 100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL mid_timeout got %0d beats need 2", out_q.size()); end
    @(posedge clk);
    #1;
    checks++; if (bus_if.m_valid !== 1'b1) begin errors++; $display("FAIL mid_pre_valid got %b need 1", bus_if.m_valid); end
    #2 rst_n = 1'b0;
    n0 = out_q.size();
    #1;
    checks++; if (bus_if.m_valid !== 1'b0) begin errors++; $display("FAIL mid_m_valid got %b need 0", bus_if.m_valid); end
    checks++; if (bus_if.m_data !== '0) begin errors++; $display("FAIL mid_m_data got %h need 0", bus_if.m_data); end
    checks++; if (bus_if.s0_ready !== 1'b0) begin errors++; $display("FAIL mid_s0_ready got %b need 0", bus_if.s0_ready); end
    @(negedge clk);
    q0.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checks++; if (dut.r_state !== ST_IDLE) begin errors++; $display("FAIL mid_state got %0d need %0d", dut.r_state, ST_IDLE); end
    checks++; if (dut.r_rr_ptr !== 1'b0) begin errors++; $display("FAIL mid_rr_ptr got %b need 0", dut.r_rr_ptr); end
    checks++; if (dut.r_beat_cnt !== '0) begin errors++; $display("FAIL mid_beat_cnt got %0d need 0", dut.r_beat_cnt); end
    repeat (4) @(negedge clk);
    checks++; if (out_q.size() != n0) begin errors++; $display("FAIL mid_replay got %0d beats need %0d", out_q.size(), n0); end
    $display("test_reset_mid: %0d beats before reset", n0);
  endtask

  initial begin
    test_reset();
    test_alternate();
    test_burst_cut();
    test_burst_share();
    test_stall();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
